// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Fetches are word-granular, so the low two address bits are always forced to zero.
    function automatic logic [FETCH_ADDR_W-1:0] align_pc(input logic [FETCH_ADDR_W-1:0] pc);
        return {pc[FETCH_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over a same-cycle push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               entry_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    do_push;
    logic                    do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is not reset; the count alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues credit-limited fetches and
// hands {pc, instr} downstream, discarding responses orphaned by a redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
    parameter int                    DATA_WIDTH = FETCH_DATA_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]      live_cnt_q, live_cnt_d;
    logic [CNT_W-1:0]      discard_cnt_q, discard_cnt_d;

    logic                  req_hs;
    logic                  rsp_live;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    fetch_entry_t          fifo_head;
    fetch_entry_t          fifo_entry;

    // Credits: buffered plus live must fit the FIFO, and every outstanding
    // request (live or doomed) must fit the response-tracking counters.
    assign imem_req_valid = !reset
        && (({1'b0, fifo_count} + {1'b0, live_cnt_q}) < DEPTH_W)
        && (({1'b0, live_cnt_q} + {1'b0, discard_cnt_q}) < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign rsp_live       = imem_rsp_valid && (discard_cnt_q == '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        live_cnt_d    = live_cnt_q;
        discard_cnt_d = discard_cnt_q;
        fifo_push     = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d    = align_pc(redirect_pc);
            rsp_pc_d      = align_pc(redirect_pc);
            live_cnt_d    = '0;
            // A response this cycle retires one tracked request whichever counter owned it.
            discard_cnt_d = discard_cnt_q + live_cnt_q + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_hs) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (imem_rsp_valid && !rsp_live) begin
                discard_cnt_d = discard_cnt_q - CNT_W'(1);
            end
            if (rsp_live) begin
                fifo_push = 1'b1;
                rsp_pc_d  = rsp_pc_q + ADDR_WIDTH'(4);
            end
            live_cnt_d = live_cnt_q + CNT_W'(req_hs) - CNT_W'(rsp_live);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            live_cnt_q    <= '0;
            discard_cnt_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            live_cnt_q    <= live_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign fifo_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign fifo_pop   = if_valid && if_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (fifo_push),
        .entry_i (fifo_entry),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign if_valid = !fifo_empty && !redirect_valid;
    assign if_instr = if_valid ? fifo_head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? fifo_head.pc : '0;

`ifndef SYNTHESIS
    // The credit rule reserves a slot for every live request, so a push can never meet a full FIFO.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(fifo_push && fifo_full));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model with programmable latency,
// request/pop monitors, and hand-computed expected addresses and instructions.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int memLat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memTxn_t;

    memTxn_t     memQ[$];
    logic [31:0] reqQ[$];
    logic [31:0] popPc[$];
    logic [31:0] popInstr[$];

    logic        monHs;
    logic        monRst;
    logic [31:0] monAddr;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    // Memory content is the address XOR a fixed tag, so each word is recognisable.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Sample handshakes at the falling edge, then update the memory right after the rising edge.
    always begin
        @(negedge clk);
        monRst  = reset;
        monHs   = !reset && imem_req_valid && imem_req_ready;
        monAddr = imem_req_addr;
        if (monHs) reqQ.push_back(monAddr);
        if (!reset && if_valid && if_ready) begin
            popPc.push_back(if_pc);
            popInstr.push_back(if_instr);
        end
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (monRst) begin
            memQ.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (monHs) memQ.push_back('{addr: monAddr, due: cyc - 1 + memLat});
            if (memQ.size() > 0 && memQ[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memData(memQ[0].addr);
                void'(memQ.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic memRdy, input logic dsRdy,
                                 input logic redir, input logic [31:0] redirPc);
        reset          = rst;
        imem_req_ready = memRdy;
        if_ready       = dsRdy;
        redirect_valid = redir;
        redirect_pc    = redirPc;
    endtask

    // Leaves the bench at the start of a cycle whose preceding edge saw reset.
    task automatic doReset(input bit checkState);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        @(negedge clk);
        if (checkState) begin
            checkOutput("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
            checkOutput("rst req_addr", imem_req_addr, 32'h0000_0000);
            checkOutput("rst if_valid", {31'b0, if_valid}, 32'd0);
            checkOutput("rst if_instr", if_instr, 32'h0000_0013);
            checkOutput("rst if_pc", if_pc, 32'h0000_0000);
        end
        reqQ.delete();
        popPc.delete();
        popInstr.delete();
        step();
    endtask

    initial begin
        logic [31:0] expPc [4];

        // Streaming at latency 1
        memLat = 1;
        doReset(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t1 c0 req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("t1 c0 req_addr", imem_req_addr, 32'h0);
        checkOutput("t1 c0 if_valid", {31'b0, if_valid}, 32'd0);
        step();
        @(negedge clk);
        checkOutput("t1 c1 req_addr", imem_req_addr, 32'h4);
        checkOutput("t1 c1 if_valid", {31'b0, if_valid}, 32'd0);
        step();
        @(negedge clk);
        checkOutput("t1 c2 if_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("t1 c2 if_pc", if_pc, 32'h0);
        checkOutput("t1 c2 if_instr", if_instr, 32'hC0DE_0000);
        step();
        @(negedge clk);
        checkOutput("t1 c3 if_pc", if_pc, 32'h4);
        checkOutput("t1 c3 if_instr", if_instr, 32'hC0DE_0004);
        repeat (6) step();
        @(negedge clk);
        expPc = '{32'h0, 32'h4, 32'h8, 32'hC};
        checkOutput("t1 req count", {31'b0, reqQ.size() >= 4}, 32'd1);
        checkOutput("t1 pop count", {31'b0, popPc.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1 req[%0d]", i), reqQ[i], expPc[i]);
            checkOutput($sformatf("t1 pc[%0d]", i), popPc[i], expPc[i]);
            checkOutput($sformatf("t1 instr[%0d]", i), popInstr[i], 32'hC0DE_0000 | expPc[i]);
        end

        // Downstream stalled: credits stop at exactly four requests
        doReset(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (8) step();
        @(negedge clk);
        checkOutput("t2 req count", reqQ.size(), 32'd4);
        checkOutput("t2 req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("t2 if_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("t2 if_pc", if_pc, 32'h0);
        step();
        if_ready = 1'b1;
        repeat (16) step();
        @(negedge clk);
        checkOutput("t2 pop count", {31'b0, popPc.size() >= 8}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t2 pc[%0d]", i), popPc[i], 32'(i * 4));
            checkOutput($sformatf("t2 instr[%0d]", i), popInstr[i], 32'hC0DE_0000 | 32'(i * 4));
        end

        // Memory not ready: request held stable
        doReset(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t3 hold%0d valid", i), {31'b0, imem_req_valid}, 32'd1);
            checkOutput($sformatf("t3 hold%0d addr", i), imem_req_addr, 32'h8);
            step();
        end
        imem_req_ready = 1'b1;
        repeat (6) step();
        @(negedge clk);
        checkOutput("t3 req[2]", reqQ[2], 32'h8);
        checkOutput("t3 req[3]", reqQ[3], 32'hC);
        checkOutput("t3 pc[2]", popPc[2], 32'h8);
        checkOutput("t3 instr[2]", popInstr[2], 32'hC0DE_0008);

        // Latency 3, two in flight, redirect to 0x100
        memLat = 3;
        doReset(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        @(negedge clk);
        checkOutput("t4 redirect if_valid", {31'b0, if_valid}, 32'd0);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t4 req_addr", imem_req_addr, 32'h0000_0100);
        repeat (12) step();
        @(negedge clk);
        checkOutput("t4 pc[0]", popPc[0], 32'h0000_0100);
        checkOutput("t4 instr[0]", popInstr[0], 32'hC0DE_0100);
        checkOutput("t4 pc[1]", popPc[1], 32'h0000_0104);

        // Redirect to unaligned 0x203 coincident with a handshake and a live response
        memLat = 1;
        doReset(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
        @(negedge clk);
        checkOutput("t5 redirect if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("t5 redirect if_instr", if_instr, 32'h0000_0013);
        checkOutput("t5 redirect req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("t5 redirect req_addr", imem_req_addr, 32'h8);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5 req_addr", imem_req_addr, 32'h0000_0200);
        checkOutput("t5 if_valid", {31'b0, if_valid}, 32'd0);
        repeat (8) step();
        @(negedge clk);
        checkOutput("t5 req[2]", reqQ[2], 32'h8);
        checkOutput("t5 req[3]", reqQ[3], 32'h0000_0200);
        checkOutput("t5 pc[0]", popPc[0], 32'h0000_0200);
        checkOutput("t5 instr[0]", popInstr[0], 32'hC0DE_0200);
        checkOutput("t5 pc[1]", popPc[1], 32'h0000_0204);

        // Address wrap from the top of memory
        doReset(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t6 req_addr top", imem_req_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        checkOutput("t6 req_addr wrap", imem_req_addr, 32'h0000_0000);
        repeat (6) step();
        @(negedge clk);
        checkOutput("t6 pc[0]", popPc[0], 32'hFFFF_FFFC);
        checkOutput("t6 instr[0]", popInstr[0], 32'h3F21_FFFC);
        checkOutput("t6 pc[1]", popPc[1], 32'h0000_0000);
        checkOutput("t6 instr[1]", popInstr[1], 32'hC0DE_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end that owns the PC and feeds decode/execute.
- Issues word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched instructions in a small prefetch FIFO and hands them downstream, each paired with its PC, over a valid/ready handshake.
- Handles control-flow redirects (taken branch/jump) by flushing the FIFO and discarding in-flight responses.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries; also the maximum number of outstanding requests. Power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order; latency ≥1 cycle; cannot be back-pressured
- imem_rsp_data  in  DATA_WIDTH  fetched instruction
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_WIDTH  new fetch address
- if_valid  out  1  instruction available downstream
- if_ready  in  1  downstream consumes
- if_instr  out  DATA_WIDTH  instruction at FIFO head
- if_pc  out  ADDR_WIDTH  PC of if_instr

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: fetch_pc=RESET_PC; FIFO empty; live_cnt=0; discard_cnt=0; imem_req_valid=0; imem_req_addr=RESET_PC; if_valid=0; if_instr=32'h0000_0013 (NOP); if_pc=0.
- Reset mid-operation: abandons all state identically. Responses arriving after reset deasserts for pre-reset requests are the memory's responsibility; the memory is reset on the same signal.
- Request issue: imem_req_valid=1 when (fifo_count + live_cnt) < FIFO_DEPTH and (live_cnt + discard_cnt) < FIFO_DEPTH. imem_req_addr = fetch_pc.
- Request accepted (valid&&ready): fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH); live_cnt++.
- Once imem_req_valid is asserted, valid and address stay stable until accepted, unless redirect_valid.
- Response handling:
  - If discard_cnt>0: drop the data and decrement discard_cnt.
  - Otherwise: push {pc, data} into the FIFO and decrement live_cnt. Entry pc is tracked by a response-PC register (rsp_pc), advanced by 4 per live response.
  - FIFO overflow is impossible by the credit rule; assert this in simulation.
- Output: if_valid = FIFO non-empty && !redirect_valid. if_instr/if_pc show the head entry. When if_valid=0 they show NOP/0. Pop when if_valid&&if_ready.
- Latency: request accepted at cycle t with response at t+L gives if_valid at t+L+1 (no bypass).
- Push and pop in the same cycle: both occur; count is unchanged.
- Redirect (highest priority), in that cycle:
  - FIFO cleared.
  - fetch_pc and rsp_pc set to {redirect_pc[ADDR_WIDTH-1:2],2'b00}.
  - discard_cnt += live_cnt, plus 1 if a request handshake occurs this cycle, plus adjustment for a response arriving this cycle: a live response in the redirect cycle is dropped and no longer counted.
  - live_cnt=0.
  - imem_req_valid is still driven per the credit rule using the old address. A handshake in the redirect cycle is counted as a discard.
- Back-to-back redirects: each independently reloads the PC and accumulates discards.
- Counter widths: $clog2(FIFO_DEPTH)+1.

Decomposition:
- fetch_pkg:
  - NOP_INSTR constant (32'h0000_0013).
  - fetch_entry_t struct {pc, instr}.
  - Helper function for the aligned PC.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full. Flush has priority over push.
- fetch_stage: PC, credit/discard counters, redirect logic.

Test Plan:
- Reset, then imem_req_ready=1 with fixed 1-cycle response latency and if_ready=1 -> addresses 0,4,8,C issued; if_pc sequence 0,4,8,C with matching data; first if_valid 2 cycles after first accept.
- if_ready=0 with ready memory, DEPTH=4 -> exactly 4 requests issued, imem_req_valid then drops; FIFO full; raising if_ready resumes in order with no loss.
- imem_req_ready low 3 cycles -> imem_req_valid and imem_req_addr=0x8 held stable throughout.
- Latency-3 memory with 2 outstanding, redirect_pc=0x100 -> both stale responses dropped; next if_pc=0x100; no stale instruction appears.
- redirect_pc=0x203 -> imem_req_addr=0x200; redirect coincident with request handshake and response -> both discarded correctly; if_valid low in redirect cycle.
- Fetch from 0xFFFF_FFFC -> next address 0x0000_0000 (wrap-around).
